sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Upstream stage of the single-port SDRAM controller.
- Generates the periodic `cyc` slot strobe and arbitrates three clients (video fetch, CPU, DMA) onto the controller's request bus.
- Routes read data returned by the controller back to the client that issued the read.
- Idle slots are issued with `REQ=0`, which the controller turns into auto-refresh.

Parameters:
- SLOT_LEN, 8: clocks per access slot; must be ≥6 so the controller is back in idle before each cyc.
- INIT_WAIT, 32: clocks after reset release before the first cyc; covers controller power-up init (≥24).
- REF_MAX, 32: max consecutive request slots before a refresh slot is forced (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cyc  out  1  one-clock slot strobe to controller
- REQ  out  1  access request (0 = refresh slot)
- RNW  out  1  1 = read, 0 = write
- A  out  24  word address
- DI  out  16  write data
- bsel  out  2  byte enables, active high
- curr_cpu  out  1  current slot owned by CPU
- DO  in  16  read data from controller
- vid_req  in  1  video read request
- vid_addr  in  24  video address
- vid_ack  out  1  video request issued
- vid_dv  out  1  video read data valid
- cpu_req  in  1  CPU request
- cpu_rnw  in  1  CPU direction
- cpu_addr  in  24  CPU address
- cpu_wdata  in  16  CPU write data
- cpu_bsel  in  2  CPU byte enables
- cpu_ack  out  1  CPU request issued
- cpu_dv  out  1  CPU read data valid
- dma_req  in  1  DMA request
- dma_rnw  in  1  DMA direction
- dma_addr  in  24  DMA address
- dma_wdata  in  16  DMA write data
- dma_bsel  in  2  DMA byte enables
- dma_ack  out  1  DMA request issued
- dma_dv  out  1  DMA read data valid
- rdata  out  16  registered read data, shared by all clients

Behaviour:
- **Reset values:** all outputs 0; slot counter 0; init counter 0; pending-read flag clear.
- **Init phase:**
  - The init counter counts INIT_WAIT clocks after rst_n rises; cyc is held low during this phase.
  - After init, the slot counter cnt runs 0..SLOT_LEN-1 and wraps.
- **Slot issue (edge where cnt==SLOT_LEN-1):**
  - Priority is fixed: vid > cpu > dma.
  - Winner's address, wdata and bsel are loaded into A, DI and bsel; RNW and REQ=1 are set.
  - curr_cpu=1 iff the winner is CPU; the winner's ack=1; cyc=1.
  - Video is always a read with bsel=2'b11.
  - If no request is pending: REQ=0, cyc=1, no ack; A, DI and bsel hold their previous values.
- **Following edge:** cyc and ack return to 0. A, DI, bsel, RNW, REQ and curr_cpu hold until the next issue.
- **Client rules:**
  - Client holds req and its fields stable until it sees ack.
  - A req still high after the ack cycle is a new request.
- **Read return:**
  - If the previous slot was a read, then at the edge where the next cyc is asserted: rdata<=DO, and the owner's dv pulses high for exactly one clock, coincident with that cyc.
  - Read latency is SLOT_LEN clocks from ack to dv.
  - Writes produce no dv.
- **Back-to-back reads:** pending owner and new owner are tracked separately. A slot can both return data to client X and grant client Y.
- **Reset mid-operation:** pending reads are discarded (no dv); init wait restarts.

Optional Feature:
- Macro: SDARB_FORCED_REFRESH_EN.
- **Defined:**
  - A counter tracks consecutive slots issued with REQ=1.
  - When it reaches REF_MAX, the next slot is forced to REQ=0 regardless of requests; no ack is issued and requesters wait.
  - The counter clears on any REQ=0 slot.
- **Undefined:** refresh occurs only on naturally idle slots; REF_MAX is unused.

Test Plan:
- **Reset release:** rst_n released, no requests → cyc low for first 32 clocks, then single-clock pulses every 8 clocks with REQ=0.
- **CPU read:** cpu_req, rnw=1, addr=0x123456 → cpu_ack and cyc together with A=0x123456, RNW=1, REQ=1, curr_cpu=1. Controller model drives DO=0xBEEF → cpu_dv one clock, 8 clocks after ack, rdata=0xBEEF.
- **Priority:** vid, cpu and dma all requesting and held until acked → acks in consecutive slots in order vid, cpu, dma. Each dv goes to the correct owner with DO values 0x1111/0x2222/0x3333.
- **DMA write:** dma write, bsel=2'b01, wdata=0x55AA, addr=0x000100 → REQ=1, RNW=0, DI=0x55AA, bsel=01, dma_ack. No dma_dv ever.
- **Forced refresh:** with macro, vid_req held high continuously → slot 33 after init has REQ=0 and no vid_ack, slot 34 resumes. Without macro, every slot has REQ=1.
- **Reset during read:** cpu read acked, rst_n pulsed low before the next cyc → no cpu_dv; all outputs 0; next cyc 32 clocks after release.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Slot generator and fixed-priority (video > CPU > DMA) arbiter in front of the single-port
// SDRAM controller; also steers returned read data. Define SDARB_FORCED_REFRESH_EN to cap request runs.
module sdram_arbiter #(
  parameter int SLOT_LEN  = 8,
  parameter int INIT_WAIT = 32,
  parameter int REF_MAX   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cyc,
  output logic        REQ,
  output logic        RNW,
  output logic [23:0] A,
  output logic [15:0] DI,
  output logic [1:0]  bsel,
  output logic        curr_cpu,
  input  logic [15:0] DO,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_dv,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_bsel,
  output logic        cpu_ack,
  output logic        cpu_dv,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [23:0] dma_addr,
  input  logic [15:0] dma_wdata,
  input  logic [1:0]  dma_bsel,
  output logic        dma_ack,
  output logic        dma_dv,
  output logic [15:0] rdata
);

  localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int IW = $clog2(INIT_WAIT + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA} owner_e;

  state_e        state_q, state_d;
  logic [IW-1:0] init_q, init_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          req_q, req_d;
  logic          rnw_q, rnw_d;
  logic [23:0]   a_q, a_d;
  logic [15:0]   di_q, di_d;
  logic [1:0]    bsel_q, bsel_d;
  logic          curr_cpu_q, curr_cpu_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          vid_dv_q, vid_dv_d;
  logic          cpu_dv_q, cpu_dv_d;
  logic          dma_dv_q, dma_dv_d;
  logic [15:0]   rdata_q, rdata_d;
  owner_e        pend_q, pend_d;

  logic          slot;
  logic          force_ref;
  owner_e        win;

`ifdef SDARB_FORCED_REFRESH_EN
  localparam int RW = $clog2(REF_MAX + 1);

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;

  assign force_ref = (ref_cnt_q == RW'(REF_MAX));

  always_comb begin
    ref_cnt_d = ref_cnt_q;
    if (slot) begin
      ref_cnt_d = (win != OWN_NONE) ? ref_cnt_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
    end
  end
`else
  // Never true; keeps the parameter referenced when forced refresh is compiled out.
  assign force_ref = (REF_MAX < 0);
`endif

  always_comb begin
    win = OWN_NONE;
    if (!force_ref) begin
      if (vid_req)      win = OWN_VID;
      else if (cpu_req) win = OWN_CPU;
      else if (dma_req) win = OWN_DMA;
    end
  end

  // The first slot fires on the last init clock, so cyc appears INIT_WAIT clocks after release.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    cnt_d   = cnt_q;
    slot    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_d = init_q + 1'b1;
        if (init_q == IW'(INIT_WAIT - 1)) begin
          slot    = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == CW'(SLOT_LEN - 1)) begin
          slot  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cyc_d      = 1'b0;
    req_d      = req_q;
    rnw_d      = rnw_q;
    a_d        = a_q;
    di_d       = di_q;
    bsel_d     = bsel_q;
    curr_cpu_d = curr_cpu_q;
    vid_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    dma_ack_d  = 1'b0;
    vid_dv_d   = 1'b0;
    cpu_dv_d   = 1'b0;
    dma_dv_d   = 1'b0;
    rdata_d    = rdata_q;
    pend_d     = pend_q;

    if (slot) begin
      cyc_d = 1'b1;
      // Data for the read issued last slot is on DO now; return it while granting anew.
      if (pend_q != OWN_NONE) begin
        rdata_d = DO;
      end
      vid_dv_d   = (pend_q == OWN_VID);
      cpu_dv_d   = (pend_q == OWN_CPU);
      dma_dv_d   = (pend_q == OWN_DMA);
      pend_d     = OWN_NONE;
      curr_cpu_d = (win == OWN_CPU);
      req_d      = (win != OWN_NONE);
      case (win)
        OWN_VID: begin
          vid_ack_d = 1'b1;
          rnw_d     = 1'b1;
          a_d       = vid_addr;
          bsel_d    = 2'b11;
          pend_d    = OWN_VID;
        end
        OWN_CPU: begin
          cpu_ack_d = 1'b1;
          rnw_d     = cpu_rnw;
          a_d       = cpu_addr;
          di_d      = cpu_wdata;
          bsel_d    = cpu_bsel;
          pend_d    = cpu_rnw ? OWN_CPU : OWN_NONE;
        end
        OWN_DMA: begin
          dma_ack_d = 1'b1;
          rnw_d     = dma_rnw;
          a_d       = dma_addr;
          di_d      = dma_wdata;
          bsel_d    = dma_bsel;
          pend_d    = dma_rnw ? OWN_DMA : OWN_NONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_q     <= '0;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      req_q      <= 1'b0;
      rnw_q      <= 1'b0;
      a_q        <= '0;
      di_q       <= '0;
      bsel_q     <= '0;
      curr_cpu_q <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      vid_dv_q   <= 1'b0;
      cpu_dv_q   <= 1'b0;
      dma_dv_q   <= 1'b0;
      rdata_q    <= '0;
      pend_q     <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      req_q      <= req_d;
      rnw_q      <= rnw_d;
      a_q        <= a_d;
      di_q       <= di_d;
      bsel_q     <= bsel_d;
      curr_cpu_q <= curr_cpu_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      dma_ack_q  <= dma_ack_d;
      vid_dv_q   <= vid_dv_d;
      cpu_dv_q   <= cpu_dv_d;
      dma_dv_q   <= dma_dv_d;
      rdata_q    <= rdata_d;
      pend_q     <= pend_d;
    end
  end

  assign cyc      = cyc_q;
  assign REQ      = req_q;
  assign RNW      = rnw_q;
  assign A        = a_q;
  assign DI       = di_q;
  assign bsel     = bsel_q;
  assign curr_cpu = curr_cpu_q;
  assign vid_ack  = vid_ack_q;
  assign cpu_ack  = cpu_ack_q;
  assign dma_ack  = dma_ack_q;
  assign vid_dv   = vid_dv_q;
  assign cpu_dv   = cpu_dv_q;
  assign dma_dv   = dma_dv_q;
  assign rdata    = rdata_q;

endmodule
